seg_hex_scroll: RTL and testbench

SEG_HEX_SCROLL -- requirements
Module: seg_hex_scroll

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_hex7.sv | 25 ++
 rtl/seg_hex_scroll.sv | 108 ++++++++++
 tb/tb_seg_hex_scroll.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: segment bit positions and the hex glyph table.
package seg_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Glyphs packed as {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
    } seg_entry_t;

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble + decimal point to active-high segment byte {a..g, dp}.
module seg_hex7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph            = HEX_GLYPH[nib];
        seg              = '0;
        seg[SEG_A_BIT]   = glyph[6];
        seg[SEG_B_BIT]   = glyph[5];
        seg[SEG_C_BIT]   = glyph[4];
        seg[SEG_D_BIT]   = glyph[3];
        seg[SEG_E_BIT]   = glyph[2];
        seg[SEG_F_BIT]   = glyph[1];
        seg[SEG_G_BIT]   = glyph[0];
        seg[SEG_DP_BIT]  = dp;
    end

endmodule

// File: rtl/seg_hex_scroll.sv
// Scrolling multi-digit hex display driver with registered active-low segment outputs.
// Optional per-entry blinking is enabled by defining SEG_BLINK_EN.
module seg_hex_scroll
    import seg_pkg::*;
#(
    parameter int NDIG    = 8,
    parameter int CLK_DIV = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(NDIG)-1:0] wr_idx,
    input  logic [3:0]              wr_data,
    input  logic                    wr_dp,
    input  logic [NDIG-1:0]         dig_en,
    input  logic                    scroll_en,
`ifdef SEG_BLINK_EN
    input  logic [NDIG-1:0]         blink_mask,
`endif
    output logic [8*NDIG-1:0]       o_seg,
    output logic [$clog2(NDIG)-1:0] o_offset
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] OFF_MAX = IW'(NDIG - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] off_q, off_d;
    logic          tick;
    seg_entry_t    buf_q [NDIG];
    seg_entry_t    buf_d [NDIG];
    logic [8*NDIG-1:0] seg_d;
    logic [8*NDIG-1:0] seg_p1;

    function automatic logic [IW-1:0] src_idx(input int pos, input logic [IW-1:0] off);
        int s;
        s = pos + int'(off);
        if (s >= NDIG) s = s - NDIG;
        return IW'(s);
    endfunction

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);
        off_d = off_q;
        if (tick && scroll_en)
            off_d = (off_q == OFF_MAX) ? '0 : off_q + IW'(1);
        buf_d = buf_q;
        for (int i = 0; i < NDIG; i++) begin
            if (wr_en && wr_idx == IW'(i))
                buf_d[i] = '{nib: wr_data, dp: wr_dp};
        end
    end

`ifdef SEG_BLINK_EN
    logic phase_q, phase_d;

    assign phase_d = phase_q ^ tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_d;
    end
`endif

    // p0: decode from next-state buffer/offset so writes and ticks land together
    for (genvar i = 0; i < NDIG; i++) begin : g_pos
        logic [IW-1:0] src;
        logic [7:0]    glyph_p0;
        logic          blank;

        assign src = src_idx(i, off_d);

        seg_hex7 u_hex7 (
            .nib (buf_d[src].nib),
            .dp  (buf_d[src].dp),
            .seg (glyph_p0)
        );

`ifdef SEG_BLINK_EN
        assign blank = ~dig_en[i] | (blink_mask[src] & phase_d);
`else
        assign blank = ~dig_en[i];
`endif
        assign seg_d[8*i +: 8] = blank ? 8'hFF : ~glyph_p0;
    end

    // p1: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            off_q  <= '0;
            buf_q  <= '{default: '0};
            seg_p1 <= '1;
        end else begin
            pre_q  <= pre_d;
            off_q  <= off_d;
            buf_q  <= buf_d;
            seg_p1 <= seg_d;
        end
    end

    assign o_seg    = seg_p1;
    assign o_offset = off_q;

endmodule

// File: tb/tb_seg_hex_scroll.sv
// Scoreboard bench for seg_hex_scroll: NDIG=8 and NDIG=6 instances against a reference model.
module tb_seg_hex_scroll;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [63:0] seg;
        logic [2:0]  off;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [3:0]  wr_data = '0;
    logic        wr_dp = 1'b0;
    logic [7:0]  dig_en = '1;
    logic        scroll_en = 1'b0;
`ifdef SEG_BLINK_EN
    logic [7:0]  blink_mask = '0;
`endif
    logic [63:0] seg8;
    logic [2:0]  off8;
    logic [47:0] seg6;
    logic [2:0]  off6;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg_hex_scroll #(.NDIG(8), .CLK_DIV(CLK_DIV)) u8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_dp(wr_dp), .dig_en(dig_en), .scroll_en(scroll_en),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .o_seg(seg8), .o_offset(off8)
    );

    seg_hex_scroll #(.NDIG(6), .CLK_DIV(CLK_DIV)) u6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_dp(wr_dp), .dig_en(dig_en[5:0]), .scroll_en(scroll_en),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask[5:0]),
`endif
        .o_seg(seg6), .o_offset(off6)
    );

    // Reference glyphs as lit segment letters
    string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] ref_byte(input int v, input bit dp);
        logic [7:0] b;
        string s;
        int k;
        b = '0;
        s = glyph_str[v];
        for (int i = 0; i < s.len(); i++) begin
            k = int'(s[i]) - 97;
            b[7-k] = 1'b1;
        end
        b[0] = dp;
        return ~b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    int         n_of [2] = '{8, 6};
    int         m_cyc = 0;
    int         m_nticks = 0;
    int         m_steps [2] = '{0, 0};
    logic [3:0] m_nib [2][16];
    bit         m_dp [2][16];
    exp_t       q8 [$];
    exp_t       q6 [$];

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc = 0;
                m_nticks = 0;
                for (int u = 0; u < 2; u++) begin
                    m_steps[u] = 0;
                    for (int e = 0; e < 16; e++) begin
                        m_nib[u][e] = '0;
                        m_dp[u][e] = 1'b0;
                    end
                end
                q8.delete();
                q6.delete();
            end else begin
                bit   tk;
                exp_t ex;
                int   n, off, s;
                logic [7:0] b;
                m_cyc++;
                tk = (m_cyc % CLK_DIV) == 0;
                if (tk) m_nticks++;
                for (int u = 0; u < 2; u++) begin
                    n = n_of[u];
                    if (wr_en && int'(wr_idx) < n) begin
                        m_nib[u][wr_idx] = wr_data;
                        m_dp[u][wr_idx] = wr_dp;
                    end
                    if (tk && scroll_en) m_steps[u]++;
                    off = m_steps[u] % n;
                    ex.seg = '0;
                    ex.off = 3'(off);
                    for (int p = 0; p < n; p++) begin
                        s = (p + off) % n;
                        b = ref_byte(int'(m_nib[u][s]), m_dp[u][s]);
                        if (!dig_en[p]) b = 8'hFF;
`ifdef SEG_BLINK_EN
                        if (blink_mask[s] && (m_nticks % 2) == 1) b = 8'hFF;
`endif
                        ex.seg[8*p +: 8] = b;
                    end
                    if (u == 0) q8.push_back(ex);
                    else        q6.push_back(ex);
                end
            end
        end
    end

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_seg8", seg8, '1);
                check("rst_off8", 64'(off8), 64'(0));
                check("rst_seg6", 64'(seg6), 64'(48'hFFFF_FFFF_FFFF));
                check("rst_off6", 64'(off6), 64'(0));
            end else begin
                if (q8.size() > 0) begin
                    ex = q8.pop_front();
                    check("sb_seg8", seg8, ex.seg);
                    check("sb_off8", 64'(off8), 64'(ex.off));
                end
                if (q6.size() > 0) begin
                    ex = q6.pop_front();
                    check("sb_seg6", 64'(seg6), 64'(ex.seg[47:0]));
                    check("sb_off6", 64'(off6), 64'(ex.off));
                end
            end
        end
    end

    task automatic wr(input logic [2:0] idx, input logic [3:0] d, input logic dp);
        wr_en = 1'b1;
        wr_idx = idx;
        wr_data = d;
        wr_dp = dp;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg8", seg8, '1);
        check("async_rst_off8", 64'(off8), 64'(0));
        check("async_rst_seg6", 64'(seg6), 64'(48'hFFFF_FFFF_FFFF));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int steps;
        int guard;
        logic [2:0] prev;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("release_zero8", seg8, {8{8'h03}});
        check("release_zero6", 64'(seg6), 64'({6{8'h03}}));

        for (int i = 0; i < 8; i++) wr(3'(i), 4'(i), 1'b0);
        check("dec_byte0", 64'(seg8[7:0]), 64'(8'h03));
        check("dec_byte1", 64'(seg8[15:8]), 64'(8'h9F));
        check("dec_byte7", 64'(seg8[63:56]), 64'(8'h1F));
        check("n6_ignore_hi_idx", 64'(seg6[47:40]), 64'(8'h49));
        wr(3'd2, 4'd2, 1'b1);
        check("dp_byte2", 64'(seg8[23:16]), 64'(8'h24));
        dig_en = 8'hFE;
        @(negedge clk);
        check("dig_en_blank", 64'(seg8[7:0]), 64'(8'hFF));
        dig_en = 8'hFF;
        @(negedge clk);

        scroll_en = 1'b1;
        steps = 0;
        prev = off8;
        repeat (32) begin
            @(negedge clk);
            if (off8 != prev) steps++;
            prev = off8;
        end
        scroll_en = 1'b0;
        check("scroll_steps", 64'(steps), 64'(8));
        check("scroll_wrap", 64'(off8), 64'(0));

        pulse_reset();
        scroll_en = 1'b1;
        guard = 0;
        while (!(((m_cyc + 1) % CLK_DIV) == 0 && (m_steps[0] % 8) == 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("tick_wait_timeout", 64'(guard), 64'(0));
        wr(3'd1, 4'hF, 1'b0);
        check("wr_tick_byte0", 64'(seg8[7:0]), 64'(8'h71));
        check("wr_tick_off", 64'(off8), 64'(1));
        scroll_en = 1'b0;

        repeat (400) begin
            wr_en = ($urandom % 3) == 0;
            wr_idx = 3'($urandom % 8);
            wr_data = 4'($urandom);
            wr_dp = 1'($urandom);
            if ($urandom % 8 == 0) dig_en = 8'($urandom);
            scroll_en = ($urandom % 4) != 0;
`ifdef SEG_BLINK_EN
            if ($urandom % 16 == 0) blink_mask = 8'($urandom);
`endif
            @(negedge clk);
        end
        wr_en = 1'b0;
        scroll_en = 1'b0;
        dig_en = 8'hFF;

`ifdef SEG_BLINK_EN
        begin
            logic [7:0] a;
            blink_mask = 8'h01;
            pulse_reset();
            repeat (2) @(negedge clk);
            a = seg8[7:0];
            repeat (4) @(negedge clk);
            check("blink_alt", 64'(a == seg8[7:0]), 64'(0));
            check("blink_steady_byte1", 64'(seg8[15:8]), 64'(8'h03));
            blink_mask = 8'h00;
        end
`endif

        pulse_reset();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
